// File: rtl/paddle_move_sched_if.sv
// Signal bundle between the paddle move scheduler and its surroundings
// (key debounce, ball tracker, paddle generator).
interface paddle_move_sched_if;
  logic        iFRAME_TICK;
  logic        iGAME_RUN;
  logic        iKEY_LEFT;
  logic        iKEY_RIGHT;
  logic        iAUTO_EN;
  logic [10:0] iBALL_X;
  logic [10:0] iBLOCK_X1;
  logic [10:0] iBLOCK_X2;
  logic        oMOVE_LEFT;
  logic        oMOVE_RIGHT;
  logic        oAUTO_ACT;

  modport master (
    output iFRAME_TICK, iGAME_RUN, iKEY_LEFT, iKEY_RIGHT, iAUTO_EN,
    output iBALL_X, iBLOCK_X1, iBLOCK_X2,
    input  oMOVE_LEFT, oMOVE_RIGHT, oAUTO_ACT
  );

  modport slave (
    input  iFRAME_TICK, iGAME_RUN, iKEY_LEFT, iKEY_RIGHT, iAUTO_EN,
    input  iBALL_X, iBLOCK_X1, iBLOCK_X2,
    output oMOVE_LEFT, oMOVE_RIGHT, oAUTO_ACT
  );
endinterface

// File: rtl/paddle_move_sched.sv
// Frame-paced paddle move scheduler: manual press-and-hold auto-repeat with an
// auto-play tracker that takes over after a period of manual inactivity.
module paddle_move_sched #(
  parameter int unsigned REPEAT_DLY = 16,
  parameter int unsigned REPEAT_PER = 4,
  parameter int unsigned AUTO_PER   = 2,
  parameter int unsigned TAKEOVER   = 120,
  parameter int unsigned DEADBAND   = 8
) (
  input logic              iCLK,
  input logic              iRST_n,
  paddle_move_sched_if.slave bus
);

  localparam int unsigned CntMax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned ToW    = $clog2(TAKEOVER + 1);
  localparam int unsigned AutoW  = (AUTO_PER > 1) ? $clog2(AUTO_PER) : 1;

  localparam logic [CntW-1:0]  DlyLast  = CntW'(REPEAT_DLY - 1);
  localparam logic [CntW-1:0]  PerLast  = CntW'(REPEAT_PER - 1);
  localparam logic [AutoW-1:0] AutoLast = AutoW'(AUTO_PER - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRpt} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;      // {left, right}, at most one bit set
  logic [ToW-1:0]   to_q, to_d;
  logic [AutoW-1:0] ac_q, ac_d;
  logic             auto_act_q, auto_act_d;
  logic             left_q, right_q;

  logic       tick, run;
  logic [1:0] dir;
  logic [1:0] man_mv, auto_mv, mv;
  logic [11:0] thr_l, thr_r, ball;

  assign tick = bus.iFRAME_TICK;
  assign run  = bus.iGAME_RUN;
  assign dir  = {bus.iKEY_LEFT & ~bus.iKEY_RIGHT, bus.iKEY_RIGHT & ~bus.iKEY_LEFT};

  // 12-bit edges so neither the +DEADBAND nor the -DEADBAND side can wrap.
  assign ball  = {1'b0, bus.iBALL_X};
  assign thr_l = {1'b0, bus.iBLOCK_X1} + 12'(DEADBAND);
  assign thr_r = ({1'b0, bus.iBLOCK_X2} < 12'(DEADBAND)) ? 12'd0
                                                         : {1'b0, bus.iBLOCK_X2} - 12'(DEADBAND);

  // State register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!run) begin
      state_d = StIdle;
    end else if (tick) begin
      case (state_q)
        StIdle: if (dir != 2'b00) state_d = StHold;
        StHold: begin
          if (dir == 2'b00)        state_d = StIdle;
          else if (dir != dir_q)   state_d = StHold;
          else if (cnt_q == DlyLast) state_d = StRpt;
        end
        StRpt: begin
          if (dir == 2'b00)      state_d = StIdle;
          else if (dir != dir_q) state_d = StHold;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic: manual move decision plus hold counter / latched direction
  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    man_mv = 2'b00;
    if (!run) begin
      cnt_d = '0;
      dir_d = 2'b00;
    end else if (tick) begin
      case (state_q)
        StIdle: begin
          if (dir != 2'b00) begin
            man_mv = dir;
            dir_d  = dir;
            cnt_d  = '0;
          end
        end
        StHold, StRpt: begin
          if (dir == 2'b00) begin
            cnt_d = '0;
          end else if (dir != dir_q) begin
            man_mv = dir;
            dir_d  = dir;
            cnt_d  = '0;
          end else if (cnt_q == ((state_q == StHold) ? DlyLast : PerLast)) begin
            man_mv = dir;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Takeover, auto frame counter and auto-play ownership
  always_comb begin
    to_d       = to_q;
    ac_d       = ac_q;
    auto_act_d = auto_act_q;
    if (!run) begin
      to_d       = '0;
      ac_d       = '0;
      auto_act_d = 1'b0;
    end else if (tick) begin
      if (dir != 2'b00)  to_d = ToW'(TAKEOVER);
      else if (to_q != '0) to_d = to_q - ToW'(1);
      ac_d       = (ac_q == AutoLast) ? '0 : ac_q + AutoW'(1);
      auto_act_d = bus.iAUTO_EN & (to_d == '0) & (state_d == StIdle);
    end
  end

  // Manual activity of any kind vetoes the tracker on this tick.
  always_comb begin
    auto_mv = 2'b00;
    if (auto_act_q && (ac_q == '0) && (dir == 2'b00) && (state_q == StIdle)) begin
      if (ball < thr_l)      auto_mv = 2'b10;
      else if (ball > thr_r) auto_mv = 2'b01;
    end
    mv = (man_mv != 2'b00) ? man_mv : auto_mv;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt_q      <= '0;
      dir_q      <= 2'b00;
      to_q       <= '0;
      ac_q       <= '0;
      auto_act_q <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      to_q       <= to_d;
      ac_q       <= ac_d;
      auto_act_q <= auto_act_d;
      left_q     <= run & tick & mv[1];
      right_q    <= run & tick & mv[0];
    end
  end

  assign bus.oMOVE_LEFT  = left_q;
  assign bus.oMOVE_RIGHT = right_q;
  assign bus.oAUTO_ACT   = auto_act_q;

endmodule

// File: tb/tb_paddle_move_sched.sv
// Directed bench for paddle_move_sched: hold/repeat timing, direction change,
// auto-play deadband edges, takeover timeout, reset and game-run suppression.
module tb_paddle_move_sched;

  logic iCLK = 1'b0;
  logic iRST_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   tk = 0;

  localparam logic [1:0] MvNone = 2'b00;
  localparam logic [1:0] MvL    = 2'b10;
  localparam logic [1:0] MvR    = 2'b01;

  paddle_move_sched_if bus ();

  paddle_move_sched dut (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .bus    (bus.slave)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One frame tick; pulse sampled one cycle after the tick, then checked cleared.
  task automatic step(input string tag, input logic [1:0] exp);
    @(negedge iCLK) bus.iFRAME_TICK = 1'b1;
    @(negedge iCLK) bus.iFRAME_TICK = 1'b0;
    check(tag, 32'({bus.oMOVE_LEFT, bus.oMOVE_RIGHT}), 32'(exp));
    @(negedge iCLK);
    check({tag, "_width"}, 32'({bus.oMOVE_LEFT, bus.oMOVE_RIGHT}), 32'(MvNone));
    tk++;
  endtask

  task automatic clear_run();
    @(negedge iCLK) bus.iGAME_RUN = 1'b0;
    @(negedge iCLK);
    @(negedge iCLK) bus.iGAME_RUN = 1'b1;
    tk = 0;
  endtask

  task automatic keys(input logic l, input logic r);
    bus.iKEY_LEFT  = l;
    bus.iKEY_RIGHT = r;
  endtask

  typedef struct {
    logic [10:0] ball;
    logic [10:0] x1;
    logic [10:0] x2;
    logic [1:0]  exp;
  } edge_vec_t;

  edge_vec_t ev[7];

  initial begin
    ev[0] = '{11'd307,  11'd300,  11'd500,  MvL};
    ev[1] = '{11'd308,  11'd300,  11'd500,  MvNone};
    ev[2] = '{11'd492,  11'd300,  11'd500,  MvNone};
    ev[3] = '{11'd493,  11'd300,  11'd500,  MvR};
    ev[4] = '{11'd10,   11'd0,    11'd5,    MvR};   // X2 < DEADBAND clamps to 0
    ev[5] = '{11'd4,    11'd0,    11'd5,    MvL};
    ev[6] = '{11'd2047, 11'd2047, 11'd2047, MvL};   // X1+DEADBAND past 11 bits

    bus.iFRAME_TICK = 1'b0;
    bus.iGAME_RUN   = 1'b1;
    bus.iAUTO_EN    = 1'b0;
    bus.iBALL_X     = 11'd0;
    bus.iBLOCK_X1   = 11'd300;
    bus.iBLOCK_X2   = 11'd500;
    keys(1'b0, 1'b0);

    repeat (2) @(negedge iCLK);
    check("rst_move", 32'({bus.oMOVE_LEFT, bus.oMOVE_RIGHT}), 32'(MvNone));
    check("rst_auto", 32'(bus.oAUTO_ACT), 32'd0);
    iRST_n = 1'b1;
    @(negedge iCLK);

    // Hold LEFT 40 ticks
    keys(1'b1, 1'b0);
    for (int k = 0; k < 40; k++)
      step($sformatf("hold_l_%0d", k),
           ((k == 0) || (k >= 16 && ((k - 16) % 4) == 0)) ? MvL : MvNone);
    keys(1'b0, 1'b0);
    step("rel1", MvNone);

    // RIGHT then switch to LEFT at tick 5
    for (int k = 0; k < 26; k++) begin
      if (k < 5) keys(1'b0, 1'b1);
      else       keys(1'b1, 1'b0);
      step($sformatf("switch_%0d", k),
           (k == 0) ? MvR : ((k == 5 || k == 21 || k == 25) ? MvL : MvNone));
    end
    keys(1'b0, 1'b0);
    step("rel2", MvNone);

    // Both keys: no direction
    keys(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step($sformatf("both_%0d", k), MvNone);
    // Key pressed only between ticks is never sampled
    keys(1'b0, 1'b0);
    @(negedge iCLK) keys(1'b1, 1'b0);
    @(negedge iCLK) keys(1'b0, 1'b0);
    step("glitch", MvNone);
    keys(1'b1, 1'b0);
    step("idle_after_both", MvL);
    keys(1'b0, 1'b0);
    step("rel3", MvNone);

    // Auto-play tracking
    clear_run();
    check("auto_clr", 32'(bus.oAUTO_ACT), 32'd0);
    bus.iAUTO_EN = 1'b1;
    bus.iBALL_X  = 11'd100;
    for (int k = 0; k < 10; k++) begin
      step($sformatf("auto_l_%0d", k), (k >= 2 && (k % 2) == 0) ? MvL : MvNone);
      if (k == 0) check("auto_act_on", 32'(bus.oAUTO_ACT), 32'd1);
    end
    bus.iBALL_X = 11'd400;
    for (int k = 10; k < 16; k++) step($sformatf("auto_in_%0d", k), MvNone);
    for (int i = 0; i < 7; i++) begin
      bus.iBALL_X   = ev[i].ball;
      bus.iBLOCK_X1 = ev[i].x1;
      bus.iBLOCK_X2 = ev[i].x2;
      step($sformatf("edge_%0d", i), ev[i].exp);
      step($sformatf("edge_%0d_odd", i), MvNone);
    end

    // Manual tap suspends auto-play for TAKEOVER ticks
    clear_run();
    bus.iBALL_X   = 11'd100;
    bus.iBLOCK_X1 = 11'd300;
    bus.iBLOCK_X2 = 11'd500;
    keys(1'b0, 1'b1);
    step("tap", MvR);
    check("tap_auto_off", 32'(bus.oAUTO_ACT), 32'd0);
    keys(1'b0, 1'b0);
    for (int k = 1; k < 126; k++) begin
      step($sformatf("takeover_%0d", k), (k >= 122 && (k % 2) == 0) ? MvL : MvNone);
      if (k == 119) check("takeover_119", 32'(bus.oAUTO_ACT), 32'd0);
      if (k == 120) check("takeover_120", 32'(bus.oAUTO_ACT), 32'd1);
    end

    // Reset mid-repeat
    bus.iAUTO_EN = 1'b0;
    clear_run();
    keys(1'b1, 1'b0);
    for (int k = 0; k < 18; k++)
      step($sformatf("pre_rst_%0d", k), (k == 0 || k == 16) ? MvL : MvNone);
    @(negedge iCLK) bus.iFRAME_TICK = 1'b1;
    #2 iRST_n = 1'b0;
    #1 check("rst_mid_move", 32'({bus.oMOVE_LEFT, bus.oMOVE_RIGHT}), 32'(MvNone));
    @(negedge iCLK) bus.iFRAME_TICK = 1'b0;
    check("rst_mid_hold", 32'({bus.oMOVE_LEFT, bus.oMOVE_RIGHT}), 32'(MvNone));
    iRST_n = 1'b1;
    repeat (3) @(negedge iCLK);
    check("rst_no_spont", 32'({bus.oMOVE_LEFT, bus.oMOVE_RIGHT}), 32'(MvNone));
    step("post_rst", MvL);
    step("post_rst_hold", MvNone);

    // GAME_RUN low during a hold
    bus.iGAME_RUN = 1'b0;
    for (int k = 0; k < 4; k++) step($sformatf("norun_%0d", k), MvNone);
    check("norun_auto", 32'(bus.oAUTO_ACT), 32'd0);
    bus.iGAME_RUN = 1'b1;
    step("run_again", MvL);
    step("run_again_hold", MvNone);
    keys(1'b0, 1'b0);
    step("final_rel", MvNone);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
